mpf_burst_reader_sm: RTL and testbench

//  Parametrised MPF read engine. Streams data_length cache lines, starting at a

---
 rtl/mpf_burst_reader_sm.sv | 197 +++++++++++++++++++
 tb/tb_mpf_burst_reader_sm.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpf_burst_reader_sm.sv
// MPF c0 read engine: streams data_length lines from a VA into a local buffer, 1-cycle registered request path,
// holds issue while c0TxAlmFull, buffer space, the in-flight cap or the throttle slot say no.
package mpf_burst_reader_pkg;
  typedef logic [41:0] t_cci_clAddr;

  localparam logic [3:0] eREQ_RDLINE_I = 4'h0;
  localparam logic [3:0] eREQ_RDLINE_S = 4'h1;
  localparam logic [3:0] eRSP_RDLINE   = 4'h0;
  localparam logic [1:0] eVC_VA        = 2'b00;

  typedef struct packed {
    logic addrIsVirtual;
    logic mapVAtoPhysChannel;
    logic checkLoadStoreOrder;
  } t_cci_mpf_ReqMemHdrExt;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    t_cci_clAddr address;
    logic [15:0] mdata;
  } t_cci_c0_ReqMemHdr;

  typedef struct packed {
    t_cci_mpf_ReqMemHdrExt ext;
    t_cci_c0_ReqMemHdr     base;
  } t_cci_mpf_c0_ReqMemHdr;

  localparam int CCI_MPF_C0TX_MEMHDR_WIDTH = $bits(t_cci_mpf_c0_ReqMemHdr);

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  function automatic logic cci_c0Rx_isReadRsp(input t_if_ccip_c0_Rx r);
    return r.rspValid && (r.hdr.resp_type == eRSP_RDLINE);
  endfunction
endpackage

module mpf_burst_reader_sm
  import mpf_burst_reader_pkg::*;
#(
  parameter int MAX_CL_LEN      = 4,
  parameter int MAX_OUTSTANDING = 32,
  parameter int THROTTLE_PERIOD = 8,
  parameter int BUF_CNT_W       = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 run,
  input  logic                                 abort,
  input  logic [63:0]                          data_length,
  input  t_cci_clAddr                          first_clAddr,
  output logic                                 done,
  output logic                                 aborted,
  input  logic                                 c0TxAlmFull,
  output logic                                 c0TxValid,
  output logic [CCI_MPF_C0TX_MEMHDR_WIDTH-1:0] reqMemHdr,
  input  t_if_ccip_c0_Rx                       c0Rx,
  output logic                                 buffer_wr_enable,
  input  logic [BUF_CNT_W-1:0]                 buf_free
);
  localparam int IF_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int THR_W = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  localparam int CMP_W = ((IF_W > BUF_CNT_W) ? IF_W : BUF_CNT_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  t_cci_clAddr           next_addr;
  logic [63:0]           issued;
  logic [63:0]           received;
  logic [IF_W-1:0]       in_flight;
  logic [THR_W-1:0]      thr;
  logic                  aborted_flag;

  logic [63:0]           remaining;
  logic [2:0]            len;
  logic [CMP_W-1:0]      need;
  logic                  issue;
  logic                  beat;
  logic                  beat_cnt;
  logic [IF_W-1:0]       in_flight_nxt;
  t_cci_mpf_c0_ReqMemHdr hdr;
  logic                  unused_rx;

  assign unused_rx = ^c0Rx;

  always_comb begin
    remaining = data_length - issued;
    if (MAX_CL_LEN >= 4 && remaining >= 64'd4 && next_addr[1:0] == 2'b00)
      len = 3'd4;
    else if (MAX_CL_LEN >= 2 && remaining >= 64'd2 && !next_addr[0])
      len = 3'd2;
    else
      len = 3'd1;

    need  = CMP_W'(in_flight) + CMP_W'(len);
    // remaining==0 keeps the len=1 fallback from issuing past the end of the job
    issue = (state == RUN) && !abort && (thr == '0) && !c0TxAlmFull &&
            (remaining != 64'd0) &&
            (need <= CMP_W'(buf_free)) && (need <= CMP_W'(MAX_OUTSTANDING));

    // beats with nothing outstanding, or arriving while idle, belong to no job
    beat     = cci_c0Rx_isReadRsp(c0Rx) && (state != IDLE);
    beat_cnt = beat && (in_flight != '0);

    in_flight_nxt = in_flight;
    if (issue)    in_flight_nxt = in_flight_nxt + IF_W'(len);
    if (beat_cnt) in_flight_nxt = in_flight_nxt - IF_W'(1);

    hdr                        = '0;
    hdr.ext.addrIsVirtual      = 1'b1;
    hdr.ext.mapVAtoPhysChannel = 1'b1;
    hdr.base.vc_sel            = eVC_VA;
    hdr.base.cl_len            = 2'(len - 3'd1);
    hdr.base.req_type          = eREQ_RDLINE_I;
    hdr.base.address           = next_addr;
    hdr.base.mdata             = '0;
  end

  assign done             = (state == IDLE);
  assign aborted          = (state == IDLE) && aborted_flag;
  assign buffer_wr_enable = beat && !aborted_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      next_addr    <= '0;
      issued       <= '0;
      received     <= '0;
      in_flight    <= '0;
      thr          <= '0;
      aborted_flag <= 1'b0;
      c0TxValid    <= 1'b0;
      reqMemHdr    <= '0;
    end else begin
      c0TxValid <= issue;
      if (issue) begin
        reqMemHdr <= hdr;
        next_addr <= next_addr + t_cci_clAddr'(len);
        issued    <= issued + 64'(len);
      end
      if (beat_cnt) received <= received + 64'd1;
      in_flight <= in_flight_nxt;

      if (state == RUN)
        thr <= (thr == THR_W'(THROTTLE_PERIOD - 1)) ? '0 : thr + THR_W'(1);
      else
        thr <= '0;

      case (state)
        IDLE: begin
          if (run) begin
            state        <= RUN;
            next_addr    <= first_clAddr;
            issued       <= '0;
            received     <= '0;
            in_flight    <= '0;
            thr          <= '0;
            aborted_flag <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            aborted_flag <= 1'b1;
            state        <= DRAIN;
          end else if (issued == data_length) begin
            state <= (in_flight == '0 && received == data_length) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (in_flight == '0 && (aborted_flag || received == data_length))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpf_burst_reader_sm.sv
// Directed bench for mpf_burst_reader_sm: in-order responder, burst log, throttled second instance.
module tb_mpf_burst_reader_sm;
  import mpf_burst_reader_pkg::*;
  localparam int W = CCI_MPF_C0TX_MEMHDR_WIDTH;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           run = 1'b0;
  logic           abort = 1'b0;
  logic [63:0]    data_length = '0;
  t_cci_clAddr    first_clAddr = '0;
  logic           done, aborted, c0TxValid, buffer_wr_enable;
  logic           c0TxAlmFull = 1'b0;
  logic [W-1:0]   reqMemHdr;
  t_if_ccip_c0_Rx c0Rx;
  logic [6:0]     buf_free = 7'd64;

  logic           run2 = 1'b0;
  logic [63:0]    len2 = '0;
  t_cci_clAddr    addr2 = '0;
  logic           done2, aborted2, vld2, wr2;
  logic [W-1:0]   hdr2;
  t_if_ccip_c0_Rx rx2;

  int checks = 0, errors = 0;
  int cyc_n, pending, beats, wr_cnt, lines_req, max_out, first_vld;
  bit rsp_on, alm_toggle;
  logic [41:0] b_addr[$];
  int          b_len[$];
  int          thr_q[$];
  logic [W-1:0] hdr0;
  t_cci_mpf_c0_ReqMemHdr h, exp_h;

  mpf_burst_reader_sm #(.MAX_CL_LEN(4), .MAX_OUTSTANDING(32), .THROTTLE_PERIOD(1), .BUF_CNT_W(7)) dut (
    .clk(clk), .reset(reset), .run(run), .abort(abort), .data_length(data_length),
    .first_clAddr(first_clAddr), .done(done), .aborted(aborted), .c0TxAlmFull(c0TxAlmFull),
    .c0TxValid(c0TxValid), .reqMemHdr(reqMemHdr), .c0Rx(c0Rx),
    .buffer_wr_enable(buffer_wr_enable), .buf_free(buf_free));

  mpf_burst_reader_sm #(.MAX_CL_LEN(4), .MAX_OUTSTANDING(32), .THROTTLE_PERIOD(4), .BUF_CNT_W(7)) u_thr (
    .clk(clk), .reset(reset), .run(run2), .abort(1'b0), .data_length(len2),
    .first_clAddr(addr2), .done(done2), .aborted(aborted2), .c0TxAlmFull(1'b0),
    .c0TxValid(vld2), .reqMemHdr(hdr2), .c0Rx(rx2),
    .buffer_wr_enable(wr2), .buf_free(7'd64));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bk(input logic [41:0] a, input int l);
    return 64'({a, 3'(l)});
  endfunction

  function automatic logic [63:0] burst(input int i);
    if (i >= b_addr.size()) return 64'd0;
    return bk(b_addr[i], b_len[i]);
  endfunction

  task automatic clr();
    cyc_n = 0; pending = 0; beats = 0; wr_cnt = 0; lines_req = 0; max_out = 0; first_vld = -1;
    b_addr.delete(); b_len.delete(); thr_q.delete();
  endtask

  // One clock: responses driven at negedge, wr_enable counted just after, registered outputs after posedge.
  task automatic cyc();
    int ln;
    if (alm_toggle) c0TxAlmFull = ~c0TxAlmFull;
    @(negedge clk);
    if (rsp_on && pending > 0) begin
      c0Rx.rspValid = 1'b1;
      pending--;
      beats++;
    end else begin
      c0Rx.rspValid = 1'b0;
    end
    #1;
    if (buffer_wr_enable) wr_cnt++;
    @(posedge clk);
    #1;
    cyc_n++;
    if (c0TxValid) begin
      h  = reqMemHdr;
      ln = int'(h.base.cl_len) + 1;
      if (b_addr.size() == 0) hdr0 = reqMemHdr;
      b_addr.push_back(h.base.address);
      b_len.push_back(ln);
      pending   += ln;
      lines_req += ln;
      if (first_vld < 0) first_vld = cyc_n;
    end
    if (lines_req - beats > max_out) max_out = lines_req - beats;
    if (vld2) thr_q.push_back(cyc_n);
  endtask

  task automatic start(input logic [63:0] len, input logic [41:0] addr);
    clr();
    data_length  = len;
    first_clAddr = addr;
    run = 1'b1;
    cyc();
    run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    c0Rx = '0; rx2 = '0; rsp_on = 1'b0; alm_toggle = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_done", 64'(done), 64'd1);
    chk("rst_aborted", 64'(aborted), 64'd0);
    chk("rst_valid", 64'(c0TxValid), 64'd0);
    chk("rst_hdr", 64'(reqMemHdr[63:0]), 64'd0);
    chk("rst_wr", 64'(buffer_wr_enable), 64'd0);

    // Throttled instance: one 4-line request every 4 cycles
    clr();
    len2 = 64'd16; run2 = 1'b1;
    cyc();
    run2 = 1'b0;
    repeat (18) cyc();
    chk("thr_count", 64'(thr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("thr_slot", 64'((i < thr_q.size()) ? thr_q[i] : -1), 64'(2 + 4 * i));

    // 1: 10 lines at 0x100 -> 4,4,2
    rsp_on = 1'b1;
    start(64'd10, 42'h100);
    chk("t1_busy", 64'(done), 64'd0);
    wait_done("t1_done", 100);
    chk("t1_latency", 64'(first_vld), 64'd2);
    chk("t1_nbursts", 64'(b_addr.size()), 64'd3);
    chk("t1_b0", burst(0), bk(42'h100, 4));
    chk("t1_b1", burst(1), bk(42'h104, 4));
    chk("t1_b2", burst(2), bk(42'h108, 2));
    chk("t1_wr", 64'(wr_cnt), 64'd10);
    exp_h = '0;
    exp_h.ext.addrIsVirtual      = 1'b1;
    exp_h.ext.mapVAtoPhysChannel = 1'b1;
    exp_h.base.vc_sel            = eVC_VA;
    exp_h.base.cl_len            = 2'b11;
    exp_h.base.req_type          = eREQ_RDLINE_I;
    exp_h.base.address           = 42'h100;
    checks++;
    assert (hdr0 === W'(exp_h)) else begin
      errors++;
      $error("FAIL t1_hdr: observed %0h expected %0h", hdr0, exp_h);
    end

    // 2: unaligned start 0x101, 7 lines -> 1,2,4
    start(64'd7, 42'h101);
    wait_done("t2_done", 100);
    chk("t2_b0", burst(0), bk(42'h101, 1));
    chk("t2_b1", burst(1), bk(42'h102, 2));
    chk("t2_b2", burst(2), bk(42'h104, 4));
    chk("t2_beats", 64'(beats), 64'd7);
    chk("t2_wr", 64'(wr_cnt), 64'd7);

    // 3: buf_free held at 3, responses withheld at first
    buf_free = 7'd3; rsp_on = 1'b0;
    start(64'd6, 42'h201);
    repeat (8) cyc();
    chk("t3_stall", 64'(b_addr.size()), 64'd2);
    rsp_on = 1'b1;
    wait_done("t3_done", 100);
    chk("t3_nbursts", 64'(b_addr.size()), 64'd4);
    chk("t3_b2", burst(2), bk(42'h204, 2));
    chk("t3_b3", burst(3), bk(42'h206, 1));
    chk("t3_maxout", 64'(max_out <= 3), 64'd1);
    chk("t3_wr", 64'(wr_cnt), 64'd6);
    buf_free = 7'd64;

    // 4: abort after two 4-line issues
    rsp_on = 1'b0;
    start(64'd16, 42'h300);
    for (int i = 0; i < 10 && b_addr.size() < 2; i++) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    repeat (5) cyc();
    chk("t4_nbursts", 64'(b_addr.size()), 64'd2);
    chk("t4_draining", 64'(done), 64'd0);
    rsp_on = 1'b1;
    wait_done("t4_done", 100);
    chk("t4_beats", 64'(beats), 64'd8);
    chk("t4_wr", 64'(wr_cnt), 64'd0);
    chk("t4_aborted", 64'(aborted), 64'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t4_idle_abort", 64'({done, aborted}), 64'd3);

    // 5: c0TxAlmFull toggling, overlapping issue and beats
    alm_toggle = 1'b1;
    start(64'd20, 42'h400);
    wait_done("t5_done", 300);
    alm_toggle = 1'b0; c0TxAlmFull = 1'b0;
    chk("t5_lines", 64'(lines_req), 64'd20);
    chk("t5_nbursts", 64'(b_addr.size()), 64'd5);
    chk("t5_wr", 64'(wr_cnt), 64'd20);
    chk("t5_aborted", 64'(aborted), 64'd0);

    // 6: zero-length job
    start(64'd0, 42'h480);
    chk("t6_run", 64'(done), 64'd0);
    cyc();
    chk("t6_done", 64'(done), 64'd1);
    repeat (3) cyc();
    chk("t6_novalid", 64'(b_addr.size()), 64'd0);

    // Reset mid-job, then a late response
    rsp_on = 1'b0;
    start(64'd16, 42'h500);
    for (int i = 0; i < 10 && b_addr.size() < 1; i++) cyc();
    chk("rst_mid_vld_before", 64'(c0TxValid), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(c0TxValid), 64'd0);
    chk("rst_mid_hdr", 64'(reqMemHdr[63:0]), 64'd0);
    chk("rst_mid_done", 64'({done, aborted}), 64'd2);
    c0Rx.rspValid = 1'b1;
    #1;
    chk("rst_mid_wr", 64'(buffer_wr_enable), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("late_rsp_wr", 64'(buffer_wr_enable), 64'd0);
    c0Rx.rspValid = 1'b0;
    clr();
    repeat (3) cyc();
    chk("late_rsp_idle", 64'({done, c0TxValid}), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
